// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Video timing generator. The defaults give XGA 1024x768 at 60 Hz from a
//   65 MHz pixel clock. It produces raw horizontal and vertical counts, the
//   hsync/vsync pulses and a visible-region flag for the line-draw/colour
//   stage. It also holds frame-stable copies of the game line endpoints, so
//   the renderer never sees them change part-way through a frame.
//
// Ports
//   clk_65M     in   pixel clock; all logic runs on the rising edge
//   clear_n     in   synchronous active-low reset
//   pause       in   1 = keep the current shadow coordinates at the frame wrap
//   x1_in..y2_in in  CW  line endpoints from game control
//   hsync       out  horizontal sync; its asserted level is SYNC_POL
//   vsync       out  vertical sync; its asserted level is SYNC_POL
//   H_count     out  17  horizontal position, 0..HPIXELS-1
//   V_count     out  17  vertical position, 0..VLINES-1
//   vid_on      out  1 inside the visible window
//   frame_tick  out  1 on the last clock of each frame
//   frame_cnt   out  16  frames completed since reset, wraps
//   x1..y2      out  CW  shadow coordinates, which change only at the frame wrap
module vga_sync_gen #(
  parameter int HPIXELS  = 1344,
  parameter int VLINES   = 806,
  parameter int HSP      = 136,
  parameter int HBP      = 296,
  parameter int HFP      = 1320,
  parameter int VSP      = 6,
  parameter int VBP      = 35,
  parameter int VFP      = 803,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 20
) (
  input  logic          clk_65M,
  input  logic          clear_n,
  input  logic          pause,
  input  logic [CW-1:0] x1_in,
  input  logic [CW-1:0] y1_in,
  input  logic [CW-1:0] x2_in,
  input  logic [CW-1:0] y2_in,
  output logic          hsync,
  output logic          vsync,
  output logic [16:0]   H_count,
  output logic [16:0]   V_count,
  output logic          vid_on,
  output logic          frame_tick,
  output logic [15:0]   frame_cnt,
  output logic [CW-1:0] x1,
  output logic [CW-1:0] y1,
  output logic [CW-1:0] x2,
  output logic [CW-1:0] y2
);

  // Elaboration-time check that the timing regions are in order.
  if (!(HSP < HBP && HBP < HFP && HFP <= HPIXELS &&
        VSP < VBP && VBP < VFP && VFP <= VLINES)) begin : g_bad_timing
    $error("vga_sync_gen: illegal timing parameters");
  end

  localparam logic [16:0] H_LAST = 17'(HPIXELS - 1);
  localparam logic [16:0] V_LAST = 17'(VLINES - 1);
  localparam logic [16:0] HSP_C  = 17'(HSP);
  localparam logic [16:0] HBP_C  = 17'(HBP);
  localparam logic [16:0] HFP_C  = 17'(HFP);
  localparam logic [16:0] VSP_C  = 17'(VSP);
  localparam logic [16:0] VBP_C  = 17'(VBP);
  localparam logic [16:0] VFP_C  = 17'(VFP);

  logic [16:0] h_nxt, v_nxt;
  logic        h_wrap, v_wrap;

  // Next-count values. Every registered output is decoded from these, so
  // each output lines up exactly with the counts shown on the same cycle.
  always_comb begin
    h_wrap = (H_count == H_LAST);
    v_wrap = (V_count == V_LAST);
    h_nxt  = h_wrap ? 17'd0 : H_count + 17'd1;
    v_nxt  = V_count;
    if (h_wrap) v_nxt = v_wrap ? 17'd0 : V_count + 17'd1;
  end

  always_ff @(posedge clk_65M) begin
    if (!clear_n) begin
      // (0,0) lies inside both sync pulses, so the syncs reset asserted.
      H_count    <= '0;
      V_count    <= '0;
      hsync      <= SYNC_POL;
      vsync      <= SYNC_POL;
      vid_on     <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
    end else begin
      H_count    <= h_nxt;
      V_count    <= v_nxt;
      hsync      <= (h_nxt < HSP_C) ? SYNC_POL : ~SYNC_POL;
      vsync      <= (v_nxt < VSP_C) ? SYNC_POL : ~SYNC_POL;
      vid_on     <= (h_nxt >= HBP_C) && (h_nxt < HFP_C) &&
                    (v_nxt >= VBP_C) && (v_nxt < VFP_C);
      frame_tick <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
      // frame_tick is high on exactly the cycle before the (0,0) wrap, so
      // the edge that leaves it is the frame-boundary edge.
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (!pause) begin
          x1 <= x1_in;
          y1 <= y1_in;
          x2 <= x2_in;
          y2 <= y2_in;
        end
      end
    end
  end

endmodule
